// File: rtl/lane_pkg.sv
// ============================================================================
// Module   : lane_pkg
// Purpose  : Shared scan-mode / FSM types and default grid geometry for the
//            lane index sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lane_pkg;

    localparam int DIM_DEFAULT    = 5;
    localparam int OFFSET_DEFAULT = 2;

    typedef enum logic [1:0] {
        MODE_IFAST  = 2'd0,
        MODE_JFAST  = 2'd1,
        MODE_PIWALK = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The reserved encoding behaves exactly like i-fast order.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_IFAST : mode_e'(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_index_map.sv
// ============================================================================
// Module   : lane_index_map
// Purpose  : Combinational (i,j) -> linear index with coordinate rotation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lane_index_map
    import lane_pkg::*;
#(
    parameter int DIM    = DIM_DEFAULT,
    parameter int OFFSET = OFFSET_DEFAULT,
    parameter int IDX_W  = $clog2(DIM*DIM),
    localparam int CW    = $clog2(DIM)
) (
    input  logic [CW-1:0]    i_i,
    input  logic [CW-1:0]    i_j,
    output logic [IDX_W-1:0] o_idx
);

    // Evaluated at 32-bit precision, then truncated to the index width.
    always_comb begin
        o_idx = IDX_W'(((32'(i_i) + 32'(OFFSET)) % 32'(DIM))
                     + 32'(DIM) * ((32'(i_j) + 32'(OFFSET)) % 32'(DIM)));
    end

endmodule

`default_nettype wire

// File: rtl/lane_index_sequencer.sv
// ============================================================================
// Module   : lane_index_sequencer
// Purpose  : Streams grid coordinates and linear indices in one of three scan
//            orders with valid/ready flow control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lane_index_sequencer
    import lane_pkg::*;
#(
    parameter int DIM    = DIM_DEFAULT,
    parameter int OFFSET = OFFSET_DEFAULT,
    parameter int IDX_W  = $clog2(DIM*DIM),
    localparam int CW    = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_i,
    output logic [CW-1:0]    out_j,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W        = $clog2(DIM*DIM + 1);
    localparam logic [CW-1:0]     c_MAX        = CW'(DIM - 1);
    localparam logic [CNT_W-1:0]  c_END_RASTER = CNT_W'(DIM*DIM - 1);
    localparam logic [CNT_W-1:0]  c_END_WALK   = CNT_W'(DIM*DIM - 2);

    state_e           r_state;
    mode_e            r_mode;
    logic [CW-1:0]    r_i;
    logic [CW-1:0]    r_j;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;
    logic             r_done;

    logic [CW-1:0]    w_ni;
    logic [CW-1:0]    w_nj;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_last_nx;
    logic [IDX_W-1:0] w_map_idx;

    always_comb begin
        w_ni = r_i;
        w_nj = r_j;
        case (r_mode)
            MODE_JFAST: begin
                if (r_j == c_MAX) begin
                    w_nj = '0;
                    w_ni = r_i + 1'b1;
                end else begin
                    w_nj = r_j + 1'b1;
                end
            end
            MODE_PIWALK: begin
                w_ni = r_j;
                w_nj = CW'((32'd2 * 32'(r_i) + 32'd3 * 32'(r_j)) % 32'(DIM));
            end
            default: begin
                if (r_i == c_MAX) begin
                    w_ni = '0;
                    w_nj = r_j + 1'b1;
                end else begin
                    w_ni = r_i + 1'b1;
                end
            end
        endcase
        // Final element is found by count so the walk's revisits cannot end it early.
        w_cnt_nx  = r_cnt + 1'b1;
        w_last_nx = (w_cnt_nx == ((r_mode == MODE_PIWALK) ? c_END_WALK : c_END_RASTER));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_IFAST;
            r_i     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_state <= ST_RUN;
                        r_mode  <= decode_mode(mode);
                        r_i     <= (decode_mode(mode) == MODE_PIWALK) ? CW'(1) : '0;
                        r_j     <= '0;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_valid && out_ready) begin
                        if (r_last) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_i     <= w_ni;
                            r_j     <= w_nj;
                            r_cnt   <= w_cnt_nx;
                            r_last  <= w_last_nx;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    lane_index_map #(
        .DIM    (DIM),
        .OFFSET (OFFSET),
        .IDX_W  (IDX_W)
    ) u_map (
        .i_i   (r_i),
        .i_j   (r_j),
        .o_idx (w_map_idx)
    );

    assign out_valid = r_valid;
    assign out_i     = r_i;
    assign out_j     = r_j;
    assign out_idx   = r_valid ? w_map_idx : '0;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lane_index_sequencer.sv
// ============================================================================
// Module   : tb_lane_index_sequencer
// Purpose  : Directed self-checking bench for lane_index_sequencer (DIM=5, OFFSET=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lane_index_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_i;
    logic [2:0] out_j;
    logic [4:0] out_idx;
    logic       out_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    lane_index_sequencer #(.DIM(5), .OFFSET(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_j     (out_j),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eidx(input int i, input int j);
        return ((i + 2) % 5) + 5 * ((j + 2) % 5);
    endfunction

    // Checks elements k0..total-1 starting at (ci,cj), then the done pulse.
    task automatic scan(input string tag, input int m, input int k0,
                        input int ci, input int cj, input int total);
        int i, j, ni, nj;
        i = ci;
        j = cj;
        for (int k = k0; k < total; k++) begin
            chk($sformatf("%s_valid_k%0d", tag, k), out_valid, 1);
            chk($sformatf("%s_i_k%0d", tag, k), out_i, i);
            chk($sformatf("%s_j_k%0d", tag, k), out_j, j);
            chk($sformatf("%s_idx_k%0d", tag, k), out_idx, eidx(i, j));
            chk($sformatf("%s_last_k%0d", tag, k), out_last, (k == total - 1) ? 1 : 0);
            chk($sformatf("%s_done_k%0d", tag, k), done, 0);
            tick();
            if (m == 0) begin
                ni = (i == 4) ? 0 : i + 1;
                nj = (i == 4) ? j + 1 : j;
            end else if (m == 1) begin
                nj = (j == 4) ? 0 : j + 1;
                ni = (j == 4) ? i + 1 : i;
            end else begin
                ni = j;
                nj = (2 * i + 3 * j) % 5;
            end
            i = ni;
            j = nj;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_valid_after"}, out_valid, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int t_m1[6];
        int t_m2[4];
        t_m1 = '{12, 17, 22, 2, 7, 13};
        t_m2 = '{13, 22, 19, 23};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; out_ready = 1'b1;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_i", out_i, 0);
        chk("rst_j", out_j, 0);
        rst = 1'b0;
        tick();

        // Mode 0 full raster, then start during DONE must be ignored
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        chk("m0_busy", busy, 1);
        scan("m0", 0, 0, 0, 0, 25);
        start = 1'b1;
        tick();
        chk("done_start_busy", busy, 0);
        chk("done_start_valid", out_valid, 0);
        chk("done_start_pulse", done, 0);
        start = 1'b0;
        tick();

        // Mode 1, mode input changed after start must not matter
        start = 1'b1; mode = 2'd1;
        tick();
        start = 1'b0; mode = 2'd3;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("m1_tab_idx_k%0d", k), out_idx, t_m1[k]);
            tick();
        end
        scan("m1", 1, 6, 1, 1, 25);
        tick();

        // Mode 2 pi-walk: 24 elements
        start = 1'b1; mode = 2'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("m2_tab_idx_k%0d", k), out_idx, t_m2[k]);
            tick();
        end
        scan("m2", 2, 4, 2, 3, 24);
        tick();

        // Backpressure at element 2
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk($sformatf("stall_idx_r%0d", r), out_idx, 14);
            chk($sformatf("stall_valid_r%0d", r), out_valid, 1);
            chk($sformatf("stall_i_r%0d", r), out_i, 2);
        end
        out_ready = 1'b1;
        scan("stall", 0, 2, 2, 0, 25);
        tick();

        // Abort at element 7 with a simultaneous handshake
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("abort_pre_idx", out_idx, 19);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done0", done, 0);
        tick();
        chk("abort_done1", done, 0);
        chk("abort_busy1", busy, 0);
        start = 1'b1; abort = 1'b1;
        tick();
        chk("sa_idle_busy", busy, 0);
        chk("sa_idle_valid", out_valid, 0);
        abort = 1'b0; mode = 2'd1;
        tick();
        start = 1'b0;
        chk("post_abort_valid", out_valid, 1);
        chk("post_abort_idx0", out_idx, 12);
        tick();
        chk("post_abort_idx1", out_idx, 17);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // Async reset mid-scan, with an ignored start during RUN
        start = 1'b1; mode = 2'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rs_idx2", out_idx, 19);
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        chk("rs_run_start_idx", out_idx, 23);
        chk("rs_run_start_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_i", out_i, 0);
        chk("arst_j", out_j, 0);
        chk("arst_last", out_last, 0);
        chk("arst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_rel_done", done, 0);
        chk("arst_rel_busy", busy, 0);
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        scan("post_rst", 0, 0, 0, 0, 25);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
